score_display_scanner: RTL and testbench

//   Drives the 4-digit multiplexed 7-segment score display.
//   - Accepts a binary score on a load pulse.
//   - Converts it to BCD sequentially (shift-add-3, one bit per cycle).
//   - Time-multiplexes the 4 anodes and feeds the selected BCD digit through the

---
 rtl/score_display_scanner_pkg.sv | 34 +++
 rtl/score_display_scanner_if.sv | 22 ++
 rtl/score_display_scanner_bin2bcd.sv | 66 ++++++
 rtl/score_display_scanner_cathode.sv | 27 ++
 rtl/score_display_scanner.sv | 80 ++++++++
 tb/tb_score_display_scanner.sv | 240 ++++++++++++++++++++++++
 6 files changed

// File: rtl/score_display_scanner_pkg.sv
// rtl/score_display_scanner_pkg.sv - shared types, constants and helpers for the score display
package score_pkg;

    localparam int SCORE_W    = 14;
    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;
    localparam logic [6:0]         BLANK_SEG = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    // Clamp an out-of-range score so the four-digit display never overflows.
    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s);
        return (s > SCORE_MAX) ? SCORE_MAX : s;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/score_display_scanner_if.sv
// rtl/score_display_scanner_if.sv - score load and display pin bundle
interface score_display_scanner_if;
    import score_pkg::*;

    logic [SCORE_W-1:0] score_in;
    logic               score_load;
    logic               busy;
    logic [3:0]         anode;
    logic [3:0]         digit;
    logic [6:0]         cathode;

    modport master (
        output score_in, score_load,
        input  busy, anode, digit, cathode
    );

    modport slave (
        input  score_in, score_load,
        output busy, anode, digit, cathode
    );

endinterface

// File: rtl/score_display_scanner_bin2bcd.sv
// rtl/score_display_scanner_bin2bcd.sv - sequential shift-add-3 binary to BCD converter
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    localparam logic [3:0] LAST_SHIFT = 4'(SCORE_W - 1);

    conv_state_e        state_q, state_d;
    logic [3:0]         cnt_q;
    logic [SCORE_W-1:0] bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;

    assign bcd_adj = add3_nibbles(bcd_q);

    // Next-state: one shift per cycle for SCORE_W cycles, then a single DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_SHIFT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and the {bcd,bin} shift datapath; starts are ignored unless idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q <= sat_score(bin);
                        bcd_q <= '0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
                    bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
                    cnt_q <= cnt_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/score_display_scanner_cathode.sv
// rtl/score_display_scanner_cathode.sv - BCD to active-low seven-segment decoder
module cathode_control
    import score_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] cathode
);

    // Segment order {a,b,c,d,e,f,g}, 0 lights a segment; non-decimal codes go dark.
    always_comb begin
        cathode = BLANK_SEG;
        case (digit)
            4'd0: cathode = 7'b0000001;
            4'd1: cathode = 7'b1001111;
            4'd2: cathode = 7'b0010010;
            4'd3: cathode = 7'b0000110;
            4'd4: cathode = 7'b1001100;
            4'd5: cathode = 7'b0100100;
            4'd6: cathode = 7'b0100000;
            4'd7: cathode = 7'b0001111;
            4'd8: cathode = 7'b0000000;
            4'd9: cathode = 7'b0000100;
            default: cathode = BLANK_SEG;
        endcase
    end

endmodule

// File: rtl/score_display_scanner.sv
// rtl/score_display_scanner.sv - four-digit multiplexed seven-segment score display
module score_display_scanner
    import score_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    score_display_scanner_if.slave  bus
);

    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic               conv_busy;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;

    logic [CW-1:0]      rcnt_q;
    logic [1:0]         idx_q, idx_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic [3:0]         anode_q, anode_d;
    logic [3:0]         digit_q, digit_d;
    logic               wrap;
    logic               blank_d;
    logic [BCD_W-1:0]   upper_d;
    logic [3:0]         one_hot_d;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bus.score_load),
        .bin   (bus.score_in),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign wrap = (rcnt_q == CNT_MAX);

    // Outputs are registered from the post-edge index and display value so a new
    // score appears on the same edge that loads the display registers.
    always_comb begin
        idx_d     = wrap ? idx_q + 2'd1 : idx_q;
        disp_d    = conv_done ? conv_bcd : disp_q;
        digit_d   = disp_d[{idx_d, 2'b00} +: 4];
        upper_d   = disp_d >> {idx_d, 2'b00};
        blank_d   = BLANK_LZ && (idx_d != 2'd0) && (upper_d == '0);
        one_hot_d = 4'b0001 << idx_d;
        anode_d   = blank_d ? 4'b1111 : ~one_hot_d;
    end

    // Refresh counter, scan index, display registers and registered pin drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt_q  <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            anode_q <= 4'b1110;
            digit_q <= 4'd0;
        end else begin
            rcnt_q  <= wrap ? '0 : rcnt_q + CW'(1);
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            anode_q <= anode_d;
            digit_q <= digit_d;
        end
    end

    cathode_control u_dec (
        .digit   (digit_q),
        .cathode (bus.cathode)
    );

    assign bus.busy  = conv_busy;
    assign bus.anode = anode_q;
    assign bus.digit = digit_q;

endmodule

// File: tb/tb_score_display_scanner.sv
// tb/tb_score_display_scanner.sv - self-checking bench for score_display_scanner
module tb_score_display_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    score_display_scanner_if bus();

    score_display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: the shown score, the pending score, cycles left until it shows,
    // and elapsed cycles since reset (the scan slot is that count divided by four).
    int m_cyc, m_left, m_shown, m_pend;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cyc <= 0; m_left <= 0; m_shown <= 0; m_pend <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_left == 0) begin
                if (bus.score_load) begin
                    m_pend <= (int'(bus.score_in) > 9999) ? 9999 : int'(bus.score_in);
                    m_left <= 15;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) m_shown <= m_pend;
            end
        end
    end

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    function automatic int pow10(int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic int m_idx();
        return (m_cyc / 4) % 4;
    endfunction

    function automatic logic [3:0] exp_digit();
        return 4'((m_shown / pow10(m_idx())) % 10);
    endfunction

    function automatic logic [3:0] exp_anode();
        int k = m_idx();
        logic [3:0] one = 4'b0001;
        if (k > 0 && m_shown < pow10(k)) return 4'b1111;
        return ~(one << k);
    endfunction

    function automatic logic [6:0] exp_cathode();
        return seg_tab[exp_digit()];
    endfunction

    function automatic logic exp_busy();
        return m_left != 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(int v);
        bus.score_in   = 14'(v);
        bus.score_load = 1'b1;
        step();
        bus.score_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (bus.anode !== 4'b1110) begin errors++; $display("FAIL reset_anode got=%b exp=1110", bus.anode); end
        checks++; if (bus.digit !== 4'd0) begin errors++; $display("FAIL reset_digit got=%0d exp=0", bus.digit); end
        checks++; if (bus.cathode !== 7'b0000001) begin errors++; $display("FAIL reset_cathode got=%b exp=0000001", bus.cathode); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_load_1234();
        int busy_cnt = 0;
        logic [3:0] want [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
        load(1234);
        for (int i = 0; i < 16; i++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            checks++; if (bus.busy !== exp_busy()) begin errors++; $display("FAIL load1234_busy cyc=%0d got=%b exp=%b", i, bus.busy, exp_busy()); end
            step();
        end
        checks++; if (busy_cnt != 15) begin errors++; $display("FAIL load1234_busy_len got=%0d exp=15", busy_cnt); end
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.anode == ~(4'(1) << k)) begin
                    checks++; if (bus.digit !== want[k]) begin errors++; $display("FAIL load1234_slot%0d got=%0d exp=%0d", k, bus.digit, want[k]); end
                end
            end
            checks++; if (bus.anode !== exp_anode()) begin errors++; $display("FAIL load1234_anode got=%b exp=%b", bus.anode, exp_anode()); end
            checks++; if (bus.cathode !== exp_cathode()) begin errors++; $display("FAIL load1234_cathode got=%b exp=%b", bus.cathode, exp_cathode()); end
            step();
        end
    endtask

    task automatic test_scan_wrap();
        logic [3:0] prev;
        int changes = 0;
        prev = bus.anode;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.anode !== prev) changes++;
            prev = bus.anode;
            checks++; if (bus.anode !== exp_anode()) begin errors++; $display("FAIL scan_anode cyc=%0d got=%b exp=%b", i, bus.anode, exp_anode()); end
            checks++; if (bus.digit !== exp_digit()) begin errors++; $display("FAIL scan_digit cyc=%0d got=%0d exp=%0d", i, bus.digit, exp_digit()); end
        end
        checks++; if (changes != 4) begin errors++; $display("FAIL scan_changes got=%0d exp=4", changes); end
    endtask

    task automatic test_saturation();
        load(12000);
        repeat (16) step();
        for (int i = 0; i < 16; i++) begin
            checks++; if (bus.digit !== 4'd9) begin errors++; $display("FAIL sat_digit got=%0d exp=9", bus.digit); end
            checks++; if (bus.anode !== exp_anode()) begin errors++; $display("FAIL sat_anode got=%b exp=%b", bus.anode, exp_anode()); end
            step();
        end
    endtask

    task automatic test_dropped();
        int busy_cnt = 0;
        load(42);
        if (bus.busy === 1'b1) busy_cnt++;
        for (int i = 1; i < 25; i++) begin
            if (i == 4) load(77); else step();
            if (bus.busy === 1'b1) busy_cnt++;
            checks++; if (bus.busy !== exp_busy()) begin errors++; $display("FAIL drop_busy cyc=%0d got=%b exp=%b", i, bus.busy, exp_busy()); end
        end
        checks++; if (busy_cnt != 15) begin errors++; $display("FAIL drop_busy_len got=%0d exp=15", busy_cnt); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (bus.anode !== exp_anode()) begin errors++; $display("FAIL drop_anode got=%b exp=%b", bus.anode, exp_anode()); end
            checks++; if (bus.digit !== exp_digit()) begin errors++; $display("FAIL drop_digit got=%0d exp=%0d", bus.digit, exp_digit()); end
            step();
        end
    endtask

    task automatic test_blanking();
        int blank_cnt = 0;
        int zero_slot = 0;
        load(7);
        repeat (16) step();
        for (int i = 0; i < 16; i++) begin
            if (bus.anode === 4'b1111) blank_cnt++;
            checks++; if (bus.anode !== exp_anode()) begin errors++; $display("FAIL blank7_anode got=%b exp=%b", bus.anode, exp_anode()); end
            checks++; if (bus.anode === 4'b1110 && bus.digit !== 4'd7) begin errors++; $display("FAIL blank7_slot0 got=%0d exp=7", bus.digit); end
            step();
        end
        checks++; if (blank_cnt != 12) begin errors++; $display("FAIL blank7_count got=%0d exp=12", blank_cnt); end
        load(0);
        repeat (16) step();
        for (int i = 0; i < 16; i++) begin
            if (bus.anode === 4'b1110 && bus.digit === 4'd0 && bus.cathode === 7'b0000001) zero_slot++;
            step();
        end
        checks++; if (zero_slot != 4) begin errors++; $display("FAIL blank0_slot0 got=%0d exp=4", zero_slot); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        load(321);
        while (bus.busy === 1'b1 && n < 20) begin step(); n++; end
        checks++; if (n >= 20) begin errors++; $display("FAIL b2b_timeout got=%0d exp<20", n); end
        load(654);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
        repeat (15) step();
        for (int i = 0; i < 16; i++) begin
            checks++; if (bus.digit !== exp_digit()) begin errors++; $display("FAIL b2b_digit got=%0d exp=%0d", bus.digit, exp_digit()); end
            checks++; if (bus.anode !== exp_anode()) begin errors++; $display("FAIL b2b_anode got=%b exp=%b", bus.anode, exp_anode()); end
            step();
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            load(int'($urandom_range(0, 16383)));
            for (int c = 0; c < int'($urandom_range(4, 30)); c++) begin
                bus.score_in   = 14'($urandom_range(0, 16383));
                bus.score_load = ($urandom_range(0, 5) == 0);
                step();
                bus.score_load = 1'b0;
                checks++; if (bus.busy !== exp_busy()) begin errors++; $display("FAIL rnd_busy got=%b exp=%b", bus.busy, exp_busy()); end
                checks++; if (bus.anode !== exp_anode()) begin errors++; $display("FAIL rnd_anode got=%b exp=%b shown=%0d", bus.anode, exp_anode(), m_shown); end
                checks++; if (bus.digit !== exp_digit()) begin errors++; $display("FAIL rnd_digit got=%0d exp=%0d shown=%0d", bus.digit, exp_digit(), m_shown); end
                checks++; if (bus.cathode !== exp_cathode()) begin errors++; $display("FAIL rnd_cathode got=%b exp=%b", bus.cathode, exp_cathode()); end
            end
        end
    endtask

    task automatic test_reset_mid();
        load(5555);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
            checks++; if (bus.digit !== 4'd0) begin errors++; $display("FAIL rstmid_digit got=%0d exp=0", bus.digit); end
            checks++; if (bus.anode !== exp_anode()) begin errors++; $display("FAIL rstmid_anode got=%b exp=%b", bus.anode, exp_anode()); end
            step();
        end
    endtask

    initial begin
        bus.score_in   = '0;
        bus.score_load = 1'b0;
        #1;
        test_reset();
        test_load_1234();
        test_scan_wrap();
        test_saturation();
        test_dropped();
        test_blanking();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
